plc_stack_core: RTL

Parametrised bit-serial PLC execution core: a 4-bit-opcode stack machine that runs a downloaded ladder-style program in a continuous scan. It reads discrete inputs, evaluates boolean logic on a bounded bit stack, drives discrete outputs and runs on-delay timers. It sits between the pad wrapper, which maps pins to `in_bits`/`out_bits`, and the program-download path.

---
 rtl/plc_pkg.sv | 45 ++++
 rtl/plc_timer_bank.sv | 46 ++++
 rtl/plc_stack_core.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/plc_pkg.sv
// Shared opcode, state encoding and small decode helpers for the PLC stack core.
package plc_pkg;

   localparam logic [3:0] OP_PUSH  = 4'd0;
   localparam logic [3:0] OP_POP   = 4'd1;
   localparam logic [3:0] OP_SET   = 4'd2;
   localparam logic [3:0] OP_RST   = 4'd3;
   localparam logic [3:0] OP_TON   = 4'd4;
   localparam logic [3:0] OP_PUSHK = 4'd5;
   localparam logic [3:0] OP_DUP   = 4'd6;
   localparam logic [3:0] OP_DROP  = 4'd7;
   localparam logic [3:0] OP_NOT   = 4'd8;
   localparam logic [3:0] OP_AND   = 4'd9;
   localparam logic [3:0] OP_OR    = 4'd10;
   localparam logic [3:0] OP_XOR   = 4'd11;
   localparam logic [3:0] OP_IMPL  = 4'd12;
   localparam logic [3:0] OP_XNOR  = 4'd13;
   localparam logic [3:0] OP_NAND  = 4'd14;
   localparam logic [3:0] OP_END   = 4'd15;

   localparam logic [1:0] ST_LOAD    = 2'd0;
   localparam logic [1:0] ST_FETCH   = 2'd1;
   localparam logic [1:0] ST_OPERAND = 2'd2;
   localparam logic [1:0] ST_FAULT   = 2'd3;

   function automatic logic op_has_operand(input logic [3:0] op);
      return ~op[3];
   endfunction

   // a is the top of stack, b the entry beneath it
   function automatic logic bin_op(input logic [3:0] op, input logic a, input logic b);
      logic r;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_IMPL: r = ~a | b;
         OP_XNOR: r = ~(a ^ b);
         OP_NAND: r = ~(a & b);
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/plc_timer_bank.sv
// On-delay timer bank: counts advance only when their TON executes, presets survive reset.
module plc_timer_bank #(
   parameter int N_TIMERS = 4,
   parameter int TIMER_W  = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               preset_we,
   input  logic [3:0]         preset_sel,
   input  logic [TIMER_W-1:0] preset_val,
   input  logic               ton_fire,
   input  logic [3:0]         ton_sel,
   input  logic               ton_en,
   output logic               ton_done
);

   logic [TIMER_W-1:0] cnt    [N_TIMERS];
   logic [TIMER_W-1:0] preset [N_TIMERS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_TIMERS; i++) begin
         if (preset_we && preset_sel == 4'(i)) preset[i] <= preset_val;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N_TIMERS; i++) begin
         if (!rst_n) begin
            cnt[i] <= '0;
         end else if (ton_fire && ton_sel == 4'(i)) begin
            if (!ton_en) cnt[i] <= '0;
            else if (tick && cnt[i] < preset[i]) cnt[i] <= cnt[i] + TIMER_W'(1);
         end
      end
   end

   // done uses the pre-increment count and the preset held before any same-cycle write
   always_comb begin
      ton_done = 1'b0;
      for (int i = 0; i < N_TIMERS; i++) begin
         if (ton_sel == 4'(i)) ton_done = ton_en && (cnt[i] >= preset[i]);
      end
   end

endmodule

// File: rtl/plc_stack_core.sv
// Bit-serial PLC stack machine running a downloaded program in a continuous scan.
// Define PLC_OUTPUT_LATCH_EN to make out_bits update only at end of scan.
module plc_stack_core
   import plc_pkg::*;
#(
   parameter int PROG_DEPTH  = 256,
   parameter int STACK_DEPTH = 16,
   parameter int N_IN        = 16,
   parameter int N_OUT       = 16,
   parameter int N_TIMERS    = 4,
   parameter int TIMER_W     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          prog_we,
   input  logic [3:0]                    prog_data,
   input  logic                          preset_we,
   input  logic [3:0]                    preset_sel,
   input  logic [TIMER_W-1:0]            preset_val,
   input  logic                          tick,
   input  logic [N_IN-1:0]               in_bits,
   output logic [N_OUT-1:0]              out_bits,
   output logic                          scan_done,
   output logic                          fault,
   output logic [$clog2(PROG_DEPTH)-1:0] pc,
   output logic [1:0]                    dbg_state
);

   localparam int PW  = $clog2(PROG_DEPTH);
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam logic [PW-1:0] PC_LAST = PW'(PROG_DEPTH - 1);

   logic [3:0]             mem [PROG_DEPTH];
   logic [PW-1:0]          ld_ptr, pc_q, pc_nxt;
   logic [1:0]             state, st_nxt;
   logic [3:0]             op_q, op_nxt, nib;
   logic [SPW-1:0]         sp_q, sp_nxt;
   logic [STACK_DEPTH-1:0] stk_q, stk_nxt;
   logic [N_OUT-1:0]       out_q, img, img_nxt;
   logic [15:0]            in_pad, img16;
   logic                   fault_q, done_q, err, scan_end, has1, has2, full;
   logic                   ton_fire, ton_done;

`ifdef PLC_OUTPUT_LATCH_EN
   logic [N_OUT-1:0] shadow_q;
   assign img = shadow_q;
`else
   assign img = out_q;
`endif

   // Download only while reset is held; the first reset cycle (state not yet LOAD) rewinds the pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (state == ST_LOAD) begin
            if (prog_we) begin
               mem[ld_ptr] <= prog_data;
               ld_ptr      <= ld_ptr + PW'(1);
            end
         end else begin
            ld_ptr <= '0;
         end
      end
   end

   always_comb begin
      nib      = mem[pc_q];
      in_pad   = 16'(in_bits);
      img16    = 16'(img);
      stk_nxt  = stk_q;
      sp_nxt   = sp_q;
      pc_nxt   = pc_q;
      st_nxt   = state;
      op_nxt   = op_q;
      err      = 1'b0;
      scan_end = 1'b0;
      ton_fire = 1'b0;
      has1     = (sp_q != '0);
      has2     = (sp_q >= SPW'(2));
      full     = (sp_q == SPW'(STACK_DEPTH));
      case (state)
         ST_FETCH: begin
            if (op_has_operand(nib)) begin
               op_nxt = nib;
               pc_nxt = pc_q + PW'(1);
               st_nxt = ST_OPERAND;
            end else begin
               if (nib == OP_NOT) begin
                  err        = !has1;
                  stk_nxt[0] = ~stk_q[0];
               end else if (nib == OP_END) begin
                  scan_end = 1'b1;
               end else begin
                  err        = !has2;
                  stk_nxt    = stk_q >> 1;
                  stk_nxt[0] = bin_op(nib, stk_q[0], stk_q[1]);
                  sp_nxt     = sp_q - SPW'(1);
               end
               if (pc_q == PC_LAST) scan_end = 1'b1;
               pc_nxt = scan_end ? '0 : pc_q + PW'(1);
            end
         end
         ST_OPERAND: begin
            st_nxt = ST_FETCH;
            case (op_q)
               OP_PUSH, OP_PUSHK, OP_DUP: begin
                  err        = full || (op_q == OP_DUP && !has1);
                  stk_nxt    = stk_q << 1;
                  stk_nxt[0] = (op_q == OP_PUSH)  ? in_pad[nib] :
                               (op_q == OP_PUSHK) ? nib[0] : stk_q[0];
                  sp_nxt     = sp_q + SPW'(1);
               end
               OP_TON: begin
                  err        = !has1;
                  ton_fire   = has1;
                  stk_nxt[0] = ton_done;
               end
               default: begin
                  err     = !has1;
                  stk_nxt = stk_q >> 1;
                  sp_nxt  = sp_q - SPW'(1);
                  // out-of-range indices land in the unused pad bits and are dropped
                  if (op_q == OP_POP) img16[nib] = stk_q[0];
                  else if (op_q == OP_SET && stk_q[0]) img16[nib] = 1'b1;
                  else if (op_q == OP_RST && stk_q[0]) img16[nib] = 1'b0;
               end
            endcase
            // pc is 0 here only when the opcode sat in the last slot and its operand wrapped
            scan_end = (pc_q == PC_LAST) || (pc_q == '0);
            pc_nxt   = scan_end ? '0 : pc_q + PW'(1);
         end
         default: ;
      endcase
      img_nxt = img16[N_OUT-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_LOAD;
         pc_q    <= '0;
         sp_q    <= '0;
         stk_q   <= '0;
         op_q    <= OP_PUSH;
         out_q   <= '0;
         fault_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef PLC_OUTPUT_LATCH_EN
         shadow_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         if (state == ST_LOAD) begin
            state <= ST_FETCH;
         end else if (state != ST_FAULT) begin
            if (err) begin
               state   <= ST_FAULT;
               fault_q <= 1'b1;
`ifdef PLC_OUTPUT_LATCH_EN
               shadow_q <= out_q;
`endif
            end else begin
               state  <= st_nxt;
               pc_q   <= pc_nxt;
               op_q   <= op_nxt;
               stk_q  <= stk_nxt;
               sp_q   <= scan_end ? '0 : sp_nxt;
               done_q <= scan_end;
`ifdef PLC_OUTPUT_LATCH_EN
               shadow_q <= img_nxt;
               if (scan_end) out_q <= img_nxt;
`else
               out_q <= img_nxt;
`endif
            end
         end
      end
   end

   plc_timer_bank #(
      .N_TIMERS (N_TIMERS),
      .TIMER_W  (TIMER_W)
   ) u_timers (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .preset_we  (preset_we),
      .preset_sel (preset_sel),
      .preset_val (preset_val),
      .ton_fire   (ton_fire),
      .ton_sel    (nib),
      .ton_en     (stk_q[0]),
      .ton_done   (ton_done)
   );

   assign out_bits  = out_q;
   assign scan_done = done_q;
   assign fault     = fault_q;
   assign pc        = pc_q;
   assign dbg_state = state;

endmodule
